// File: rtl/move_list_builder.sv
// -----------------------------------------------------------------------------
// move_list_builder
//
// Producer side of the packed move-list interface feeding the cube-state
// updater. Moves arrive one per handshake and are packed first-move-highest
// into a MAX_MOVES*MOVE_W list (slot k at [LIST_W-1-MOVE_W*k -: MOVE_W]).
// On seq_done the list is announced with a one-cycle new_moves_ready strobe
// and then held bit-stable until the updater answers with state_updated.
//
// Optional feature (macro CANCEL_INVERSE_EN):
//   When defined, a legal move equal to the last slot XOR 1 (same face,
//   opposite direction) removes that last slot instead of being appended.
//   When undefined, every legal move is appended and no compare logic exists.
//
// Ports
//   clock            in   system clock
//   reset_n          in   synchronous active-low reset
//   move_in          in   move code (0 = NULL, 2..13 legal, 1/14/15 illegal)
//   move_valid       in   move_in valid this cycle
//   move_ready       out  builder accepts moves (FILL state)
//   seq_done         in   end of sequence, issue the list
//   moves            out  packed move list, unused slots 0
//   new_moves_ready  out  one-cycle strobe: moves valid
//   state_updated    in   updater finished applying the list
//   move_count       out  slots currently filled
//   overflow         out  sticky: move offered while list full
//   bad_move         out  sticky: illegal code offered
// -----------------------------------------------------------------------------
module move_list_builder #(
  parameter  int MAX_MOVES = 50,
  parameter  int MOVE_W    = 4,
  localparam int LIST_W    = MAX_MOVES * MOVE_W,
  localparam int CNT_W     = $clog2(MAX_MOVES + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [MOVE_W-1:0] move_in,
  input  logic              move_valid,
  output logic              move_ready,
  input  logic              seq_done,
  output logic [LIST_W-1:0] moves,
  output logic              new_moves_ready,
  input  logic              state_updated,
  output logic [CNT_W-1:0]  move_count,
  output logic              overflow,
  output logic              bad_move
);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LIST_W-1:0] moves_q, moves_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q, ready_d;
  logic              nmr_q, nmr_d;
  logic              ovf_q, ovf_d;
  logic              bad_q, bad_d;

  logic              code_null;
  logic              code_bad;
  logic              list_full;
  logic [LIST_W-1:0] moves_app;

  // Codes 1, 14 and 15 have no face/direction meaning.
  function automatic logic is_bad_code(input logic [MOVE_W-1:0] c);
    return (c == MOVE_W'(1)) || (c == MOVE_W'(14)) || (c == MOVE_W'(15));
  endfunction

`ifdef CANCEL_INVERSE_EN
  logic [MOVE_W-1:0] last_slot;
  logic [LIST_W-1:0] moves_cnl;
  logic              cancel_hit;
`endif

  always_comb begin
    code_null = (move_in == '0);
    code_bad  = is_bad_code(move_in);
    list_full = (count_q >= CNT_W'(MAX_MOVES));

    // List with move_in written into the next free slot.
    moves_app = moves_q;
    for (int k = 0; k < MAX_MOVES; k++) begin
      if (count_q == CNT_W'(k)) begin
        moves_app[(MAX_MOVES-1-k)*MOVE_W +: MOVE_W] = move_in;
      end
    end
  end

`ifdef CANCEL_INVERSE_EN
  always_comb begin
    // Last filled slot and the list with that slot cleared.
    last_slot = '0;
    moves_cnl = moves_q;
    for (int k = 0; k < MAX_MOVES; k++) begin
      if (count_q == CNT_W'(k + 1)) begin
        last_slot = moves_q[(MAX_MOVES-1-k)*MOVE_W +: MOVE_W];
        moves_cnl[(MAX_MOVES-1-k)*MOVE_W +: MOVE_W] = '0;
      end
    end
    // Inverse pairs differ only in bit 0 (R=2/Ri=3, U=4/Ui=5, ...).
    cancel_hit = (count_q != '0) && (move_in == (last_slot ^ MOVE_W'(1)));
  end
`endif

  always_comb begin
    state_d = state_q;
    moves_d = moves_q;
    count_d = count_q;
    ready_d = ready_q;
    nmr_d   = 1'b0;
    ovf_d   = ovf_q;
    bad_d   = bad_q;

    unique case (state_q)
      FILL: begin
        ready_d = 1'b1;
        // A move offered together with seq_done is still taken in.
        if (move_valid && !code_null) begin
          if (code_bad) begin
            bad_d = 1'b1;
          end
`ifdef CANCEL_INVERSE_EN
          else if (cancel_hit) begin
            moves_d = moves_cnl;
            count_d = count_q - CNT_W'(1);
          end
`endif
          else if (!list_full) begin
            moves_d = moves_app;
            count_d = count_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (seq_done) begin
          state_d = ISSUE;
          nmr_d   = 1'b1;
          ready_d = 1'b0;
        end
      end

      ISSUE: begin
        ready_d = 1'b0;
        state_d = WAIT_DONE;
      end

      WAIT_DONE: begin
        ready_d = 1'b0;
        if (state_updated) begin
          moves_d = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          bad_d   = 1'b0;
          ready_d = 1'b1;
          state_d = FILL;
        end
      end

      default: begin
        state_d = FILL;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= FILL;
      moves_q <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      nmr_q   <= 1'b0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      moves_q <= moves_d;
      count_q <= count_d;
      ready_q <= ready_d;
      nmr_q   <= nmr_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

  assign moves           = moves_q;
  assign move_count      = count_q;
  assign move_ready      = ready_q;
  assign new_moves_ready = nmr_q;
  assign overflow        = ovf_q;
  assign bad_move        = bad_q;

endmodule

// File: tb/tb_move_list_builder.sv
// -----------------------------------------------------------------------------
// tb_move_list_builder
//
// Directed, table-driven bench for move_list_builder. Each table row gives the
// inputs applied for one clock and the outputs expected just after that edge.
// Hand-written sequences cover list-full behaviour and reset in WAIT_DONE.
// -----------------------------------------------------------------------------
module tb_move_list_builder;

  logic         clock;
  logic         reset_n;
  logic [3:0]   move_in;
  logic         move_valid;
  logic         move_ready;
  logic         seq_done;
  logic [199:0] moves;
  logic         new_moves_ready;
  logic         state_updated;
  logic [5:0]   move_count;
  logic         overflow;
  logic         bad_move;

  int checks = 0;
  int errors = 0;

  move_list_builder dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .move_in         (move_in),
    .move_valid      (move_valid),
    .move_ready      (move_ready),
    .seq_done        (seq_done),
    .moves           (moves),
    .new_moves_ready (new_moves_ready),
    .state_updated   (state_updated),
    .move_count      (move_count),
    .overflow        (overflow),
    .bad_move        (bad_move)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       vld;
    logic [3:0] code;
    logic       done;
    logic       upd;
    logic [5:0] cnt;
    logic       rdy;
    logic       nmr;
    logic       ovf;
    logic       bad;
    logic [19:0] top;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic vld, logic [3:0] code, logic done, logic upd,
                              logic [5:0] cnt, logic rdy, logic nmr, logic ovf,
                              logic bad, logic [19:0] top);
    vec_t v;
    v.vld = vld; v.code = code; v.done = done; v.upd = upd;
    v.cnt = cnt; v.rdy = rdy; v.nmr = nmr; v.ovf = ovf; v.bad = bad; v.top = top;
    return v;
  endfunction

  task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic vld, input logic [3:0] code, input logic done, input logic upd);
    move_valid    = vld;
    move_in       = code;
    seq_done      = done;
    state_updated = upd;
    @(posedge clock);
    #1;
    move_valid    = 1'b0;
    move_in       = 4'h0;
    seq_done      = 1'b0;
    state_updated = 1'b0;
  endtask

  logic [199:0] all_r;
  logic [199:0] rest;

  initial begin
    all_r         = {50{4'h2}};
    reset_n       = 1'b0;
    move_valid    = 1'b0;
    move_in       = 4'h0;
    seq_done      = 1'b0;
    state_updated = 1'b0;

    // Reset for two cycles
    repeat (2) @(posedge clock);
    #1;
    check("rst_moves", moves, '0);
    check("rst_count", 200'(move_count), 200'd0);
    check("rst_ready", 200'(move_ready), 200'd1);
    check("rst_nmr",   200'(new_moves_ready), 200'd0);
    check("rst_ovf",   200'(overflow), 200'd0);
    check("rst_bad",   200'(bad_move), 200'd0);
    reset_n = 1'b1;

    //           vld code done upd  cnt rdy nmr ovf bad top
    tbl.push_back(mk(1, 4'd2, 0, 0, 6'd1, 1, 0, 0, 0, 20'h20000));
    tbl.push_back(mk(1, 4'd4, 0, 0, 6'd2, 1, 0, 0, 0, 20'h24000));
    tbl.push_back(mk(1, 4'd7, 0, 0, 6'd3, 1, 0, 0, 0, 20'h24700));
    tbl.push_back(mk(0, 4'd0, 1, 0, 6'd3, 0, 1, 0, 0, 20'h24700));
    tbl.push_back(mk(0, 4'd0, 0, 0, 6'd3, 0, 0, 0, 0, 20'h24700));
    tbl.push_back(mk(1, 4'd2, 0, 0, 6'd3, 0, 0, 0, 0, 20'h24700));
    tbl.push_back(mk(0, 4'd0, 1, 0, 6'd3, 0, 0, 0, 0, 20'h24700));
    tbl.push_back(mk(0, 4'd0, 0, 1, 6'd0, 1, 0, 0, 0, 20'h00000));
    tbl.push_back(mk(1, 4'd1, 0, 0, 6'd0, 1, 0, 0, 1, 20'h00000));
    tbl.push_back(mk(1, 4'd14,0, 0, 6'd0, 1, 0, 0, 1, 20'h00000));
    tbl.push_back(mk(1, 4'd0, 0, 0, 6'd0, 1, 0, 0, 1, 20'h00000));
    tbl.push_back(mk(0, 4'd0, 0, 1, 6'd0, 1, 0, 0, 1, 20'h00000));
    tbl.push_back(mk(0, 4'd0, 1, 0, 6'd0, 0, 1, 0, 1, 20'h00000));
    tbl.push_back(mk(0, 4'd0, 0, 1, 6'd0, 0, 0, 0, 1, 20'h00000));
    tbl.push_back(mk(0, 4'd0, 0, 1, 6'd0, 1, 0, 0, 0, 20'h00000));
`ifdef CANCEL_INVERSE_EN
    tbl.push_back(mk(1, 4'd2, 0, 0, 6'd1, 1, 0, 0, 0, 20'h20000));
    tbl.push_back(mk(1, 4'd3, 0, 0, 6'd0, 1, 0, 0, 0, 20'h00000));
    tbl.push_back(mk(1, 4'd2, 0, 0, 6'd1, 1, 0, 0, 0, 20'h20000));
    tbl.push_back(mk(1, 4'd4, 0, 0, 6'd2, 1, 0, 0, 0, 20'h24000));
    tbl.push_back(mk(1, 4'd5, 0, 0, 6'd1, 1, 0, 0, 0, 20'h20000));
    tbl.push_back(mk(0, 4'd0, 1, 0, 6'd1, 0, 1, 0, 0, 20'h20000));
    tbl.push_back(mk(0, 4'd0, 0, 0, 6'd1, 0, 0, 0, 0, 20'h20000));
`else
    tbl.push_back(mk(1, 4'd2, 0, 0, 6'd1, 1, 0, 0, 0, 20'h20000));
    tbl.push_back(mk(1, 4'd3, 0, 0, 6'd2, 1, 0, 0, 0, 20'h23000));
    tbl.push_back(mk(1, 4'd2, 0, 0, 6'd3, 1, 0, 0, 0, 20'h23200));
    tbl.push_back(mk(1, 4'd4, 0, 0, 6'd4, 1, 0, 0, 0, 20'h23240));
    tbl.push_back(mk(1, 4'd5, 0, 0, 6'd5, 1, 0, 0, 0, 20'h23245));
    tbl.push_back(mk(0, 4'd0, 1, 0, 6'd5, 0, 1, 0, 0, 20'h23245));
    tbl.push_back(mk(0, 4'd0, 0, 0, 6'd5, 0, 0, 0, 0, 20'h23245));
`endif
    tbl.push_back(mk(0, 4'd0, 0, 1, 6'd0, 1, 0, 0, 0, 20'h00000));
    tbl.push_back(mk(1, 4'd10,1, 0, 6'd1, 0, 1, 0, 0, 20'hA0000));
    tbl.push_back(mk(0, 4'd0, 0, 0, 6'd1, 0, 0, 0, 0, 20'hA0000));
    tbl.push_back(mk(0, 4'd0, 0, 1, 6'd0, 1, 0, 0, 0, 20'h00000));

    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].code, tbl[i].done, tbl[i].upd);
      rest = moves;
      rest[199:180] = '0;
      check($sformatf("v%0d_count", i), 200'(move_count), 200'(tbl[i].cnt));
      check($sformatf("v%0d_ready", i), 200'(move_ready), 200'(tbl[i].rdy));
      check($sformatf("v%0d_nmr",   i), 200'(new_moves_ready), 200'(tbl[i].nmr));
      check($sformatf("v%0d_ovf",   i), 200'(overflow), 200'(tbl[i].ovf));
      check($sformatf("v%0d_bad",   i), 200'(bad_move), 200'(tbl[i].bad));
      check($sformatf("v%0d_top",   i), 200'(moves[199:180]), 200'(tbl[i].top));
      check($sformatf("v%0d_rest",  i), rest, '0);
    end

    // Fill the list completely, then probe the full boundary
    for (int n = 0; n < 50; n++) step(1'b1, 4'd2, 1'b0, 1'b0);
    check("full_count", 200'(move_count), 200'd50);
    check("full_moves", moves, all_r);
    check("full_ovf",   200'(overflow), 200'd0);
    step(1'b1, 4'd3, 1'b0, 1'b0);
`ifdef CANCEL_INVERSE_EN
    check("full_cancel_count", 200'(move_count), 200'd49);
    check("full_cancel_ovf",   200'(overflow), 200'd0);
    step(1'b1, 4'd2, 1'b0, 1'b0);
    check("refill_count", 200'(move_count), 200'd50);
    step(1'b1, 4'd2, 1'b0, 1'b0);
`else
    check("full_ri_count", 200'(move_count), 200'd50);
`endif
    check("ovf_count", 200'(move_count), 200'd50);
    check("ovf_flag",  200'(overflow), 200'd1);
    check("ovf_moves", moves, all_r);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("full_issue_nmr", 200'(new_moves_ready), 200'd1);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    check("full_wait_nmr",   200'(new_moves_ready), 200'd0);
    check("full_wait_ready", 200'(move_ready), 200'd0);
    check("full_wait_moves", moves, all_r);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("full_clr_ovf",   200'(overflow), 200'd0);
    check("full_clr_count", 200'(move_count), 200'd0);
    check("full_clr_moves", moves, '0);

    // Reset while waiting for the updater
    for (int n = 0; n < 10; n++) step(1'b1, 4'd12, 1'b0, 1'b0);
    check("r6_count10", 200'(move_count), 200'd10);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    check("r6_wait_ready", 200'(move_ready), 200'd0);
    reset_n = 1'b0;
    step(1'b0, 4'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    check("r6_moves", moves, '0);
    check("r6_count", 200'(move_count), 200'd0);
    check("r6_ready", 200'(move_ready), 200'd1);
    check("r6_nmr",   200'(new_moves_ready), 200'd0);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("r6_upd_ready", 200'(move_ready), 200'd1);
    check("r6_upd_count", 200'(move_count), 200'd0);
    step(1'b1, 4'd4, 1'b0, 1'b0);
    check("r6_fill_count", 200'(move_count), 200'd1);
    check("r6_fill_slot0", 200'(moves[199:196]), 200'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
